// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode encodings and
// the saturating-add helper used in front of the first pipeline slot.
package addsub_pkg;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    // Saturating unsigned add of two operands of up to 16 bits.
    // Returns {ovf, res[16:0]}: res is clamped to 2^width-1 when the true sum
    // exceeds it, and ovf flags that the clamp happened.
    function automatic logic [17:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input int          width);
        logic [17:0] sum;
        logic [17:0] max_val;
        sum     = {2'b00, a} + {2'b00, b};
        max_val = (18'd1 << width) - 18'd1;
        if (sum > max_val) begin
            sat_add = {1'b1, max_val[16:0]};
        end else begin
            sat_add = {1'b0, sum[16:0]};
        end
    endfunction

endpackage

// File: rtl/addsub_slot.sv
// One pipeline register slot: a valid bit plus the result word and overflow
// flag. Loads when the advance chain says the slot may move; flush empties it
// without touching the data.
module addsub_slot #(
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic          valid_d,
    input  logic [DW-1:0] res_d,
    input  logic          ovf_d,
    output logic          valid_q,
    output logic [DW-1:0] res_q,
    output logic          ovf_q
);

    // Slot register: reset clears everything, flush drops only the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= valid_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined unsigned add/subtract unit with valid/ready on both sides.
// The arithmetic sits combinationally in front of slot 0; STAGES register
// slots follow, chained by an advance signal that lets bubbles collapse and
// gives full backpressure. The result is WIDTH+1 bits, two's complement.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [WIDTH-1:0]        aIn,
    input  logic [WIDTH-1:0]        bIn,
    input  logic                    mode,
    output logic                    outValid,
    input  logic                    outReady,
    output logic signed [WIDTH:0]   resOut,
    output logic                    ovfOut
);

    localparam int RW = WIDTH + 1;
    localparam int EW = WIDTH + 2;

    logic [EW-1:0]     a_ext;
    logic [EW-1:0]     b_ext;
    logic [EW-1:0]     diff;
    logic [17:0]       sat_word;
    logic [RW-1:0]     res_calc;
    logic              ovf_calc;
    logic              in_fire;
    logic              unused_bits;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] ovf_q;
    logic [RW-1:0]     res_q [STAGES];
    logic [STAGES-1:0] advance;

    // Operands are widened by two bits so the difference keeps its sign and
    // the sum keeps its carry before being narrowed to the result width.
    assign a_ext    = {2'b00, aIn};
    assign b_ext    = {2'b00, bIn};
    assign diff     = a_ext - b_ext;
    assign sat_word = sat_add(16'(aIn), 16'(bIn), WIDTH);

    // Only the low RW bits of each intermediate are meaningful.
    assign unused_bits = ^{sat_word, diff};

    // Select the arithmetic result for the incoming transaction; subtraction
    // can never leave the result range, so it never reports overflow.
    always_comb begin
        res_calc = diff[RW-1:0];
        ovf_calc = 1'b0;
        if (mode == MODE_ADD) begin
            res_calc = sat_word[RW-1:0];
            ovf_calc = sat_word[17];
        end
    end

    // Advance chain from the output back to slot 0: a slot may load when the
    // slot it feeds is empty or is itself moving on this edge.
    always_comb begin
        advance = '0;
        advance[STAGES-1] = !valid_q[STAGES-1] || outReady;
        for (int i = STAGES - 2; i >= 0; i--) begin
            advance[i] = !valid_q[i] || advance[i+1];
        end
    end

    assign inReady = advance[0];
    assign in_fire = inValid && inReady;

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic          valid_d;
        logic [RW-1:0] res_d;
        logic          ovf_d;

        if (i == 0) begin : g_head
            assign valid_d = in_fire;
            assign res_d   = res_calc;
            assign ovf_d   = ovf_calc;
        end else begin : g_body
            assign valid_d = valid_q[i-1];
            assign res_d   = res_q[i-1];
            assign ovf_d   = ovf_q[i-1];
        end

        addsub_slot #(
            .DW(RW)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (flush),
            .load   (advance[i]),
            .valid_d(valid_d),
            .res_d  (res_d),
            .ovf_d  (ovf_d),
            .valid_q(valid_q[i]),
            .res_q  (res_q[i]),
            .ovf_q  (ovf_q[i])
        );
    end

    assign outValid = valid_q[STAGES-1];
    assign resOut   = res_q[STAGES-1];
    assign ovfOut   = ovf_q[STAGES-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=4, STAGES=2). A FIFO-level model
// predicts, every cycle, whether a result must be presented, what it is, and
// whether the unit can take operands; directed cases pin exact values.
module tb_addsub_pipe;

    localparam int W = 4;
    localparam int S = 2;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        int in_edge;
        int res;
        int ovf;
    } item_t;

    logic                clk;
    logic                rst_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        a_in;
    logic [W-1:0]        b_in;
    logic                mode;
    logic                out_valid;
    logic                out_ready;
    logic signed [W:0]   res_out;
    logic                ovf_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int prev_exit = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    item_t exp_q[$];
    int got_q[$];
    logic [W-1:0] sa[$];
    logic [W-1:0] sb[$];
    logic         sm[$];

    addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .inValid (in_valid),
        .inReady (in_ready),
        .aIn     (a_in),
        .bIn     (b_in),
        .mode    (mode),
        .outValid(out_valid),
        .outReady(out_ready),
        .resOut  (res_out),
        .ovfOut  (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to timestamp transfers for the model.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int modelRes(input int a, input int b, input int m);
        if (m == 1) return (a + b > MAXV) ? MAXV : a + b;
        return a - b;
    endfunction

    function automatic int modelOvf(input int a, input int b, input int m);
        return (m == 1 && a + b > MAXV) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic m, input logic ordy);
        in_valid  = v;
        a_in      = a;
        b_in      = b;
        mode      = m;
        out_ready = ordy;
    endtask

    // Model: items leave in order; the head shows up S-1 edges after its
    // input transfer, but not before the edge on which its predecessor left.
    always @(negedge clk) begin
        int  arr;
        bit  exp_v;
        bit  exp_r;
        item_t it;
        if (!rst_n) begin
            exp_q.delete();
            prev_exit = 0;
            checkOutput("rst_outValid", int'(out_valid), 0);
            checkOutput("rst_resOut", int'(res_out), 0);
            checkOutput("rst_ovfOut", int'(ovf_out), 0);
        end else begin
            exp_v = 1'b0;
            if (exp_q.size() > 0) begin
                arr = exp_q[0].in_edge + S - 1;
                if (prev_exit > arr) arr = prev_exit;
                exp_v = (arr <= cyc);
            end
            checkOutput("mon_outValid", int'(out_valid), int'(exp_v));
            if (exp_v) begin
                checkOutput("mon_resOut", int'(res_out), exp_q[0].res);
                checkOutput("mon_ovfOut", int'(ovf_out), exp_q[0].ovf);
            end
            exp_r = (exp_q.size() < S) || out_ready;
            checkOutput("mon_inReady", int'(in_ready), int'(exp_r));
            if (flush) begin
                exp_q.delete();
                prev_exit = 0;
            end else begin
                if (out_valid && out_ready) begin
                    got_q.push_back(int'(res_out));
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    prev_exit = cyc + 1;
                    out_cnt++;
                end
                if (in_valid && in_ready) begin
                    it.in_edge = cyc + 1;
                    it.res     = modelRes(int'(a_in), int'(b_in), int'(mode));
                    it.ovf     = modelOvf(int'(a_in), int'(b_in), int'(mode));
                    exp_q.push_back(it);
                    in_cnt++;
                end
            end
        end
    end

    // One isolated transaction on an empty pipe with the consumer always ready.
    task automatic checkOne(input int a, input int b, input int m,
                            input int exp_res, input int exp_ovf, input string name);
        applyStimulus(1'b1, W'(a), W'(b), m[0], 1'b1);
        @(negedge clk);
        checkOutput({name, "_inReady"}, int'(in_ready), 1);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput({name, "_early"}, int'(out_valid), 0);
        @(posedge clk); #1;
        checkOutput({name, "_valid"}, int'(out_valid), 1);
        checkOutput({name, "_res"}, int'(res_out), exp_res);
        checkOutput({name, "_ovf"}, int'(ovf_out), exp_ovf);
        @(posedge clk); #1;
        checkOutput({name, "_gone"}, int'(out_valid), 0);
    endtask

    // Push every queued operand set; outReady is random, or low for stall_len
    // cycles after the first accept.
    task automatic streamItems(input int stall_len, input bit rand_ready, input bit check_stall);
        int  idx = 0;
        int  since = -1;
        int  budget = 0;
        bit  acc;
        bit  ordy;
        bit  stall_seen = 0;
        while (idx < sa.size() && budget < 4000) begin
            if (rand_ready) ordy = ($urandom_range(0, 1) == 1);
            else ordy = !(since >= 0 && since < stall_len);
            applyStimulus(1'b1, sa[idx], sb[idx], sm[idx], ordy);
            @(negedge clk);
            acc = in_ready;
            if (check_stall && !in_ready && !stall_seen) begin
                stall_seen = 1;
                checkOutput("bp_stall_after", idx, 2);
            end
            @(posedge clk); #1;
            budget++;
            if (since >= 0) since++;
            if (acc) begin
                idx++;
                if (since < 0) since = 0;
            end
        end
        if (budget >= 4000) checkOutput("stream_budget", idx, sa.size());
        if (check_stall) checkOutput("bp_stall_seen", int'(stall_seen), 1);
    endtask

    task automatic drain();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (3 * S + 4) @(posedge clk);
        #1;
    endtask

    task automatic loadTwo();
        applyStimulus(1'b1, 4'd6, 4'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 4'd8, 4'd3, 1'b1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("two_loaded_valid", int'(out_valid), 1);
        checkOutput("two_loaded_res", int'(res_out), 4);
    endtask

    initial begin
        int in0;
        int out0;
        // Reset with a valid operand pending: nothing may leak through.
        rst_n = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b1, 4'd3, 4'd1, 1'b0, 1'b1);
        #36;
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("rst_inReady", int'(in_ready), 1);
        checkOutput("rst_idle_valid", int'(out_valid), 0);

        // Directed subtracts and saturating adds.
        checkOne(3, 10, 0, -7, 0, "sub_3_10");
        checkOne(15, 0, 0, 15, 0, "sub_15_0");
        checkOne(0, 15, 0, -15, 0, "sub_0_15");
        checkOne(7, 8, 1, 15, 0, "add_7_8");
        checkOne(9, 8, 1, 15, 1, "add_9_8");
        checkOne(15, 15, 1, 15, 1, "add_15_15");
        checkOne(0, 0, 1, 0, 0, "add_0_0");

        // Backpressure stream.
        sa = '{4'd1, 4'd5, 4'd9, 4'd2};
        sb = '{4'd1, 4'd2, 4'd4, 4'd7};
        sm = '{1'b0, 1'b0, 1'b0, 1'b0};
        got_q.delete();
        streamItems(4, 1'b0, 1'b1);
        drain();
        checkOutput("bp_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            checkOutput("bp_out0", got_q[0], 0);
            checkOutput("bp_out1", got_q[1], 3);
            checkOutput("bp_out2", got_q[2], 5);
            checkOutput("bp_out3", got_q[3], -5);
        end

        // Full-rate random traffic with random consumer stalls.
        sa.delete(); sb.delete(); sm.delete();
        for (int i = 0; i < 200; i++) begin
            sa.push_back(W'($urandom_range(0, MAXV)));
            sb.push_back(W'($urandom_range(0, MAXV)));
            sm.push_back($urandom_range(0, 1) == 1);
        end
        in0 = in_cnt;
        out0 = out_cnt;
        streamItems(0, 1'b1, 1'b0);
        drain();
        checkOutput("rand_in_count", in_cnt - in0, 200);
        checkOutput("rand_out_count", out_cnt - out0, 200);

        // Flush with two items in flight and an input offered in the flush cycle.
        loadTwo();
        flush = 1'b1;
        applyStimulus(1'b1, 4'd9, 4'd9, 1'b1, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("flush_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        checkOutput("flush_discard", int'(out_valid), 0);
        checkOne(4, 1, 0, 3, 0, "after_flush");

        // Asynchronous reset in the middle of a cycle.
        loadTwo();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", int'(out_valid), 0);
        checkOutput("async_rst_res", int'(res_out), 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        @(posedge clk); #1;
        checkOutput("post_rst_valid", int'(out_valid), 0);
        checkOne(2, 1, 0, 1, 0, "after_reset");

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
